data_mem_ctrl: RTL and testbench
================================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, meaning byte-address width from datapath.
REQ-002 Parameter DATA_W, default 32, meaning data word width.
REQ-003 Parameter TIMEOUT, default 16, meaning maximum cycles to wait for mem_ack.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 MemRead  input  1  datapath load request, level.
REQ-007 MemWrite  input  1  datapath store request, level.
REQ-008 DataAddress  input  ADDR_W  byte address from ALU result.
REQ-009 DataToRam  input  DATA_W  store data.
REQ-010 DataFromRam  output  DATA_W  load data returned to datapath.
REQ-011 stall  output  1  high = hold PC and register writeback this cycle.
REQ-012 mem_req  output  1  external memory request, held until ack or timeout.
REQ-013 mem_we  output  1  external write enable, valid with mem_req.
REQ-014 mem_addr  output  ADDR_W-2  word address = DataAddress[ADDR_W-1:2].
REQ-015 mem_wdata  output  DATA_W  write data, valid with mem_req.
REQ-016 mem_rdata  input  DATA_W  read data, sampled on the cycle mem_ack is high.
REQ-017 mem_ack  input  1  one-cycle completion pulse from memory.
REQ-018 err_misalign  output  1  one-cycle pulse on misaligned access.
REQ-019 err_timeout  output  1  sticky flag; cleared only by reset.

Function
REQ-020 FSM states IDLE, REQ, DONE; reset state IDLE.
REQ-021 IDLE, no access (MemRead=MemWrite=0): stall=0, mem_req=0, remain IDLE.
REQ-022 IDLE, access with DataAddress[1:0]!=0: no memory request, err_misalign=1 for one cycle, stall=0, DataFromRam=0, remain IDLE.
REQ-023 IDLE, aligned access: stall=1 combinationally; latch address, write data and type; go to REQ next edge.
REQ-024 MemRead and MemWrite both high: treated as write; no read issued.
REQ-025 REQ: mem_req=1, mem_we/mem_addr/mem_wdata driven from latched values and stable; stall=1; wait-counter increments each cycle.
REQ-026 REQ with mem_ack=1: for reads, capture mem_rdata into the read register; go to DONE.
REQ-027 REQ with wait-counter reaching TIMEOUT-1 and no ack: drop mem_req, set err_timeout, load read register with 0, go to DONE.
REQ-028 mem_ack and timeout on the same cycle: ack wins, no error.
REQ-029 DONE: stall=0, DataFromRam = read register; unconditionally return to IDLE next edge (the datapath advances on this edge).
REQ-030 Minimum access latency: 2 stalled cycles (IDLE detect, REQ with immediate ack), then one DONE cycle.
REQ-031 DataFromRam holds the last read register value outside DONE; it is never X after reset.
REQ-032 mem_ack while in IDLE or DONE is ignored.

Reset
REQ-033 On rst_n low, asynchronously: FSM=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, read register=0, wait-counter=0, err_timeout=0, err_misalign=0.
REQ-034 Reset during REQ aborts the access; mem_req drops without waiting for the clock edge.
REQ-035 After reset release, the first access is accepted on the first rising edge with rst_n high.

Structure
REQ-036 A shared package holds the FSM state enumeration and default ADDR_W, DATA_W, TIMEOUT constants.
REQ-037 The wait-counter is a sub-module, mem_wait_timer (clear, enable, expired output), parameterised by TIMEOUT.
REQ-038 The external port connects to the team's existing word-addressed data RAM model via an ack-generating wrapper.

Verification
REQ-039 Aligned read, addr 0x10, ack one cycle after req, mem_rdata 0xDEADBEEF -> mem_addr=0x04, stall high 2 cycles, DataFromRam=0xDEADBEEF in DONE.
REQ-040 Write, addr 0xFC, data 0x12345678, ack after 3 cycles -> mem_we=1, mem_addr=0x3F, mem_wdata stable throughout, stall high 4 cycles.
REQ-041 Read addr 0x05 -> err_misalign pulse, mem_req never asserted, stall=0.
REQ-042 Read, ack withheld -> mem_req drops after 16 cycles, err_timeout=1 and stays set, DataFromRam=0.
REQ-043 MemRead=MemWrite=1, addr 0x20 -> single write issued, no read.
REQ-044 rst_n low in the 2nd REQ cycle -> mem_req=0 immediately; after release, FSM in IDLE and next read completes normally.

Source files
------------

// File: rtl/data_mem_ctrl_pkg.sv
// data_mem_ctrl_pkg
// Shared definitions for the data memory controller:
//   - state_t     : controller FSM states (IDLE, REQ, DONE)
//   - DEF_ADDR_W  : default byte-address width
//   - DEF_DATA_W  : default data word width
//   - DEF_TIMEOUT : default number of REQ cycles allowed before giving up on mem_ack
package data_mem_ctrl_pkg;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer
// Counts the cycles spent waiting for the external memory to acknowledge.
// Ports:
//   clk     in  : clock, rising edge
//   rst_n   in  : asynchronous active-low reset
//   clear   in  : synchronous clear, has priority over enable
//   enable  in  : advance the count by one this cycle
//   expired out : count has reached TIMEOUT-1 (the last permitted wait cycle)
module mem_wait_timer
    import data_mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // The count saturates at LAST so it can never wrap back to an
    // unexpired value while the controller is still sitting in REQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
// Bridges the datapath load/store request to a handshaked, word-addressed
// external memory. Aligned accesses stall the datapath until the memory
// acknowledges (or the wait times out); misaligned accesses are rejected.
// Ports:
//   clk, rst_n   in  : clock (rising edge), asynchronous active-low reset
//   MemRead      in  : load request (level)
//   MemWrite     in  : store request (level), wins over MemRead
//   DataAddress  in  : byte address [ADDR_W]
//   DataToRam    in  : store data [DATA_W]
//   DataFromRam  out : load data, valid in DONE [DATA_W]
//   stall        out : hold PC and writeback this cycle
//   mem_req      out : external request, high for the whole REQ state
//   mem_we       out : external write enable
//   mem_addr     out : word address [ADDR_W-2]
//   mem_wdata    out : external write data [DATA_W]
//   mem_rdata    in  : external read data, sampled with mem_ack [DATA_W]
//   mem_ack      in  : one-cycle completion pulse
//   err_misalign out : pulse on a misaligned access
//   err_timeout  out : sticky, set when mem_ack never arrives
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] DataAddress,
    input  logic [DATA_W-1:0] DataToRam,
    output logic [DATA_W-1:0] DataFromRam,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              err_misalign,
    output logic              err_timeout
);

    state_t state;
    state_t state_next;

    logic              access;
    logic              aligned;
    logic              start;
    logic              expired;
    logic              we_q;
    logic [ADDR_W-3:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              timeout_q;

    assign access  = MemRead | MemWrite;
    assign aligned = (DataAddress[1:0] == 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // mem_req is decoded from the state register, so an asynchronous reset
    // during REQ removes the request immediately.
    // err_misalign is qualified with rst_n so it stays low while reset is held.
    always_comb begin
        state_next   = state;
        stall        = 1'b0;
        mem_req      = 1'b0;
        start        = 1'b0;
        err_misalign = 1'b0;
        DataFromRam  = rdata_q;
        unique case (state)
            IDLE: begin
                if (access) begin
                    if (aligned) begin
                        stall      = 1'b1;
                        start      = 1'b1;
                        state_next = REQ;
                    end else begin
                        err_misalign = rst_n;
                        DataFromRam  = '0;
                    end
                end
            end
            REQ: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                if (mem_ack || expired) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture the access on acceptance so the external bus stays stable even
    // if the datapath changes its inputs while stalled. A simultaneous
    // read+write request is recorded as a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (start) begin
            we_q    <= MemWrite;
            addr_q  <= DataAddress[ADDR_W-1:2];
            wdata_q <= DataToRam;
        end
    end

    // Ack is tested before expiry, so an ack on the final wait cycle still
    // completes cleanly. A timeout zeroes the read register so a failed load
    // never returns stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q   <= '0;
            timeout_q <= 1'b0;
        end else if (state == REQ) begin
            if (mem_ack) begin
                if (!we_q) begin
                    rdata_q <= mem_rdata;
                end
            end else if (expired) begin
                rdata_q   <= '0;
                timeout_q <= 1'b1;
            end
        end
    end

    mem_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state != REQ),
        .enable (state == REQ),
        .expired(expired)
    );

    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign err_timeout = timeout_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl
// Self-checking bench for data_mem_ctrl: directed vector table, a reset
// during an outstanding request, and randomized accesses predicted by a
// transaction-level model of the controller's rules.
module tb_data_mem_ctrl;

    localparam int TIMEOUT = 16;

    logic        clk;
    logic        rst_n;
    logic        MemRead;
    logic        MemWrite;
    logic [7:0]  DataAddress;
    logic [31:0] DataToRam;
    logic [31:0] DataFromRam;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        err_misalign;
    logic        err_timeout;

    // delay: REQ cycle (1-based) in which mem_ack is returned; 0 or beyond
    // TIMEOUT means the memory never answers.
    typedef struct {
        logic        rd;
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] rdata;
        int          exp_stall;
        int          exp_req;
        int          exp_mis;
        logic        exp_we;
        logic [31:0] exp_data;
        logic        exp_to;
    } vec_t;

    int checks = 0;
    int errors = 0;

    int          m_stall;
    int          m_req;
    int          m_mis;
    bit          m_done;
    bit          m_unstable;
    logic        m_we;
    logic [5:0]  m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_data;
    logic        m_to;

    logic [31:0] model_rr;
    logic        model_to;

    vec_t vecs[10];
    vec_t post_reset_vec;

    data_mem_ctrl #(
        .ADDR_W (8),
        .DATA_W (32),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .DataAddress (DataAddress),
        .DataToRam   (DataToRam),
        .DataFromRam (DataFromRam),
        .stall       (stall),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .err_misalign(err_misalign),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    // Holds reset across two edges, checks the reset state, releases just
    // after a rising edge so the caller can start an access immediately.
    task automatic doReset();
        rst_n       = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        DataAddress = 8'h00;
        DataToRam   = 32'h0;
        mem_rdata   = 32'h0;
        mem_ack     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.stall",       32'(stall),       32'h0);
        checkOutput("reset.mem_req",     32'(mem_req),     32'h0);
        checkOutput("reset.mem_we",      32'(mem_we),      32'h0);
        checkOutput("reset.mem_addr",    32'(mem_addr),    32'h0);
        checkOutput("reset.mem_wdata",   mem_wdata,        32'h0);
        checkOutput("reset.DataFromRam", DataFromRam,      32'h0);
        checkOutput("reset.err_timeout", 32'(err_timeout), 32'h0);
        MemRead     = 1'b1;
        DataAddress = 8'h05;
        #1;
        checkOutput("reset.err_misalign", 32'(err_misalign), 32'h0);
        MemRead     = 1'b0;
        DataAddress = 8'h00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Runs one datapath access from just after a rising edge, acting as the
    // memory responder, and records what the DUT did until stall drops.
    task automatic applyStimulus(input vec_t v);
        m_stall     = 0;
        m_req       = 0;
        m_mis       = 0;
        m_done      = 1'b0;
        m_unstable  = 1'b0;
        m_we        = 1'b0;
        m_addr      = '0;
        m_wdata     = '0;
        m_data      = '0;
        MemRead     = v.rd;
        MemWrite    = v.wr;
        DataAddress = v.addr;
        DataToRam   = v.wdata;
        mem_rdata   = v.rdata;
        mem_ack     = 1'b0;
        for (int c = 0; c < 40 && !m_done; c++) begin
            @(negedge clk);
            if (stall) m_stall++;
            if (err_misalign) m_mis++;
            if (mem_req) begin
                if (m_req == 0) begin
                    m_we    = mem_we;
                    m_addr  = mem_addr;
                    m_wdata = mem_wdata;
                end else if (mem_we !== m_we || mem_addr !== m_addr || mem_wdata !== m_wdata) begin
                    m_unstable = 1'b1;
                end
                m_req++;
            end
            mem_ack = mem_req && (m_req == v.delay);
            if (!stall) begin
                m_done    = 1'b1;
                m_data    = DataFromRam;
                MemRead   = 1'b0;
                MemWrite  = 1'b0;
                mem_ack   = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end
        end
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        m_to    = err_timeout;
    endtask

    task automatic checkAccess(input string tag, input vec_t v);
        checkOutput({tag, ".completed"},       32'(m_done),  32'h1);
        checkOutput({tag, ".stall_cycles"},    32'(m_stall), 32'(v.exp_stall));
        checkOutput({tag, ".req_cycles"},      32'(m_req),   32'(v.exp_req));
        checkOutput({tag, ".misalign_pulses"}, 32'(m_mis),   32'(v.exp_mis));
        checkOutput({tag, ".DataFromRam"},     m_data,       v.exp_data);
        checkOutput({tag, ".err_timeout"},     32'(m_to),    32'(v.exp_to));
        if (m_req > 0) begin
            checkOutput({tag, ".mem_we"},      32'(m_we),       32'(v.exp_we));
            checkOutput({tag, ".mem_addr"},    32'(m_addr),     32'(v.addr[7:2]));
            checkOutput({tag, ".bus_unstable"}, 32'(m_unstable), 32'h0);
            if (v.exp_we) begin
                checkOutput({tag, ".mem_wdata"}, m_wdata, v.wdata);
            end
        end
    endtask

    // Transaction-level prediction: only the externally visible rules
    // (alignment, write priority, ack-or-timeout, sticky error) are modelled.
    task automatic predict(inout vec_t v);
        bit acked;
        int n;
        v.exp_stall = 0;
        v.exp_req   = 0;
        v.exp_mis   = 0;
        v.exp_we    = 1'b0;
        v.exp_data  = model_rr;
        if (v.rd || v.wr) begin
            if (v.addr % 4 != 0) begin
                v.exp_mis  = 1;
                v.exp_data = 32'h0;
            end else begin
                acked       = (v.delay >= 1) && (v.delay <= TIMEOUT);
                n           = acked ? v.delay : TIMEOUT;
                v.exp_stall = n + 1;
                v.exp_req   = n;
                v.exp_we    = v.wr;
                if (acked) begin
                    if (!v.wr) model_rr = v.rdata;
                end else begin
                    model_rr = 32'h0;
                    model_to = 1'b1;
                end
                v.exp_data = model_rr;
            end
        end
        v.exp_to = model_to;
    endtask

    initial begin
        //          rd    wr    addr   wdata         dly rdata         stl req mis we    data          to
        vecs[0] = '{1'b1, 1'b0, 8'h10, 32'h00000000,  1, 32'hDEADBEEF,  2,  1, 0, 1'b0, 32'hDEADBEEF, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 8'hFC, 32'h12345678,  3, 32'h00000000,  4,  3, 0, 1'b1, 32'hDEADBEEF, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 8'h05, 32'h00000000,  1, 32'h77777777,  0,  0, 1, 1'b0, 32'h00000000, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 8'h20, 32'hA5A5A5A5,  2, 32'h11111111,  3,  2, 0, 1'b1, 32'hDEADBEEF, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 8'h40, 32'h00000000, 16, 32'hCAFEF00D, 17, 16, 0, 1'b0, 32'hCAFEF00D, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 8'h00, 32'h00000000,  1, 32'h22222222,  0,  0, 0, 1'b0, 32'hCAFEF00D, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 8'h02, 32'h33333333,  1, 32'h00000000,  0,  0, 1, 1'b0, 32'h00000000, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 8'h30, 32'h00000000,  0, 32'h00000055, 17, 16, 0, 1'b0, 32'h00000000, 1'b1};
        vecs[8] = '{1'b1, 1'b0, 8'h08, 32'h00000000,  1, 32'h01020304,  2,  1, 0, 1'b0, 32'h01020304, 1'b1};
        vecs[9] = '{1'b0, 1'b1, 8'h0C, 32'h0F0F0F0F, 17, 32'h00000000, 17, 16, 0, 1'b1, 32'h00000000, 1'b1};
        post_reset_vec = '{1'b1, 1'b0, 8'h14, 32'h0, 2, 32'h0BADCAFE, 3, 2, 0, 1'b0, 32'h0BADCAFE, 1'b0};

        doReset();

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
            checkAccess($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset asserted in the second REQ cycle must drop mem_req at once.
        MemRead     = 1'b1;
        MemWrite    = 1'b0;
        DataAddress = 8'h10;
        mem_ack     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        MemRead = 1'b0;
        @(negedge clk);
        checkOutput("rstReq.mem_req_before", 32'(mem_req), 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("rstReq.mem_req_async",     32'(mem_req),     32'h0);
        checkOutput("rstReq.stall_async",       32'(stall),       32'h0);
        checkOutput("rstReq.mem_addr_async",    32'(mem_addr),    32'h0);
        checkOutput("rstReq.err_timeout_async", 32'(err_timeout), 32'h0);
        checkOutput("rstReq.DataFromRam_async", DataFromRam,      32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(post_reset_vec);
        checkAccess("postReset", post_reset_vec);

        // Randomized accesses against the transaction model.
        doReset();
        model_rr = 32'h0;
        model_to = 1'b0;
        for (int i = 0; i < 40; i++) begin
            vec_t v;
            v.rd    = 1'($urandom_range(0, 1));
            v.wr    = 1'($urandom_range(0, 1));
            v.addr  = 8'($urandom);
            if ($urandom_range(0, 3) != 0) v.addr[1:0] = 2'b00;
            v.wdata = $urandom;
            v.rdata = $urandom;
            v.delay = $urandom_range(0, 18);
            predict(v);
            applyStimulus(v);
            checkAccess($sformatf("rand%0d", i), v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
